// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and the default operand width.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

endpackage

// File: rtl/hilo_md_unit_if.sv
// Request/result bundle between the core control and the HI/LO mul/div unit.
interface hilo_md_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             hi_sel;
  logic [WIDTH-1:0] hilo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata, hi_sel,
    input  hilo, hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata, hi_sel,
    output hilo, hi, lo, busy, done
  );

endinterface

// File: rtl/md_datapath.sv
// Iterative shift-add multiplier and restoring divider working on operand
// magnitudes, with the final sign fix-up applied combinationally.
module md_datapath
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);

  logic [2*WIDTH-1:0] acc_q, prod;
  logic [WIDTH-1:0]   mcand_q, rem_q, quo_q, div_q, rawA_q;
  logic               negRes_q, negRem_q, isDiv_q, divZero_q;

  logic               signedOp, aNeg, bNeg;
  logic [WIDTH-1:0]   magA, magB, quot, remv;
  logic [WIDTH:0]     mulSum, trial, diff;

  always_comb begin
    signedOp = (op == MD_MULT) || (op == MD_DIV);
    aNeg     = signedOp & a[WIDTH-1];
    bNeg     = signedOp & b[WIDTH-1];
    magA     = aNeg ? -a : a;
    magB     = bNeg ? -b : b;
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    trial    = {rem_q, quo_q[WIDTH-1]};
    diff     = trial - {1'b0, div_q};
  end

  // The multiplier rides in the low half of acc and is consumed one bit per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      rawA_q    <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      isDiv_q   <= 1'b0;
      divZero_q <= 1'b0;
    end else if (load) begin
      acc_q     <= {{WIDTH{1'b0}}, magB};
      mcand_q   <= magA;
      rem_q     <= '0;
      quo_q     <= magA;
      div_q     <= magB;
      rawA_q    <= a;
      negRes_q  <= aNeg ^ bNeg;
      negRem_q  <= aNeg;
      isDiv_q   <= op[1];
      divZero_q <= (b == '0);
    end else if (step) begin
      acc_q <= {mulSum, acc_q[WIDTH-1:1]};
      if (diff[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    prod = negRes_q ? -acc_q : acc_q;
    quot = negRes_q ? -quo_q : quo_q;
    remv = negRem_q ? -rem_q : rem_q;
    if (!isDiv_q) begin
      resHi = prod[2*WIDTH-1:WIDTH];
      resLo = prod[WIDTH-1:0];
    end else if (divZero_q) begin
      resHi = rawA_q;
      resLo = '1;
    end else begin
      resHi = remv;
      resLo = quot;
    end
  end

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO register file with the mul/div sequencing FSM; drives the MFHI/MFLO
// word and the busy stall seen by the core control.
module hilo_md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  hilo_md_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             load, step;
  logic [WIDTH-1:0] resHi, resLo;

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .op    (bus.op),
    .a     (bus.a),
    .b     (bus.b),
    .resHi (resHi),
    .resLo (resLo)
  );

  // Moves are only honoured in IDLE without a competing start; HI/LO change nowhere but here.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      ST_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = resHi;
        lo_d    = resLo;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.hilo = bus.hi_sel ? hi_q : lo_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;

endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles; also services MTHI and MTLO.
- Drives the `hilo` word consumed by the writeback select (its m5reg=3'b011 input), plus a `busy` stall to the PC/control logic.
- Sits in the execute/writeback boundary of the 54-instruction MIPS core.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  core clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a mul/div operation
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  data for MTHI/MTLO
- hi_sel  input  1  1 selects HI onto hilo (MFHI), 0 selects LO (MFLO)
- hilo  output  WIDTH  hi_sel ? HI : LO, combinational from registers
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in progress; control stalls while high
- done  output  1  one-cycle pulse: result now visible in HI/LO

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, busy=0, done=0, FSM to IDLE. Applies mid-operation: the operation is aborted and no partial result is written.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 latches op, a and b; records operand signs for the signed ops (MULT, DIV).
  - Converts operands to magnitudes (two's complement of negative values).
  - Clears the counter and goes to RUN. busy=1 from the next cycle.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Exactly WIDTH steps, counter 0..WIDTH-1, then go to FIX.
- FIX (1 cycle):
  - Applies sign correction.
  - Product is negated if the operand signs differ (signed op only).
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Writes HI/LO: multiply → HI=product[2W-1:W], LO=product[W-1:0]; divide → HI=remainder, LO=quotient.
  - Returns to IDLE.
- Timing: if start is accepted at edge k, busy=1 during cycles k+1 .. k+WIDTH+1 (WIDTH+1 cycles). At edge k+WIDTH+1 HI/LO are written and busy falls. done=1 for the single cycle after that edge.
- start while busy is ignored; there is no queueing.
- Divide by zero: completes with normal latency, HI = a (raw, unsigned view), LO = all ones. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (magnitude result truncates naturally).
- MTHI/MTLO:
  - Accepted only in IDLE with start=0; the register updates at the next edge.
  - mthi and mtlo in the same cycle write both registers with wdata.
  - While busy they are ignored. If start and mthi/mtlo arrive in the same cycle, start wins and the move is dropped.
- hilo, hi and lo always reflect the current registers. During RUN/FIX the pre-operation values are held until FIX writes the result.
- Arithmetic: multiply uses a 2·WIDTH accumulator with a WIDTH-bit magnitude multiplier. Divide uses a (WIDTH+1)-bit partial remainder. All negation is modulo 2^WIDTH (or 2^(2·WIDTH) for the product).

Decomposition:
- Shared package `md_pkg`:
  - op encodings MD_MULTU=2'b00, MD_MULT=2'b01, MD_DIVU=2'b10, MD_DIV=2'b11.
  - FSM state encoding.
  - WIDTH default.
- One natural sub-module, `md_datapath`: iterative accumulator/remainder registers and sign fix.
- Top level `hilo_md_unit` holds the FSM, the counter, the HI/LO registers and the hilo select.

Test Plan:
- Reset mid-run: start MULTU a=5 b=7, assert rst at busy cycle 10 → next cycle busy=0, HI=0, LO=0, no done pulse.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 busy cycles done=1, HI=0xFFFFFFFE, LO=0x00000001; hi_sel=1 gives hilo=0xFFFFFFFE.
- MULT a=0xFFFFFFFD (-3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); a second start asserted during busy is ignored and produces no extra done.
- DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU a=100, b=7 → LO=14, HI=2.
- DIVU a=0x1234, b=0 → LO=0xFFFFFFFF, HI=0x1234.
- MTHI wdata=0xDEADBEEF in IDLE → HI=0xDEADBEEF next cycle, LO unchanged. MTLO during busy → ignored, LO equals the mul/div result.
